// File: rtl/serial_cmp_pkg.sv
// rtl/serial_cmp_pkg.sv - shared types, mode constants and sizing helper for the serial comparator
package serial_cmp_pkg;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_e;

   localparam logic CMP_UNSIGNED = 1'b0;
   localparam logic CMP_SIGNED   = 1'b1;

   function automatic int clog2(input int value);
      int r;
      int v;
      r = 0;
      v = value - 1;
      while (v > 0) begin
         r = r + 1;
         v = v >> 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/serial_comparator_di_if.sv
// rtl/serial_comparator_di_if.sv - start/busy/done handshake, operands and result flags
interface serial_comparator_di_if #(
   parameter int WIDTH = 8
);
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             signed_mode;
   logic             busy;
   logic             done;
   logic             lt;
   logic             eq;
   logic             gt;

   modport master (
      output start, a, b, signed_mode,
      input  busy, done, lt, eq, gt
   );

   modport slave (
      input  start, a, b, signed_mode,
      output busy, done, lt, eq, gt
   );
endinterface

// File: rtl/lt_digit_di.sv
// rtl/lt_digit_di.sv - chain of DIGIT LSB-first less-than/equal propagation cells
module lt_digit_di #(
   parameter int DIGIT = 1
) (
   input  logic [DIGIT-1:0] a_d,
   input  logic [DIGIT-1:0] b_d,
   input  logic             n_in,
   input  logic             e_in,
   input  logic             msb_swap,
   output logic             n_out,
   output logic             e_out
);
   logic ai;
   logic bi;

   // msb_swap turns the sign bit around so a negative A ranks below a positive B
   always_comb begin
      n_out = n_in;
      e_out = e_in;
      ai    = 1'b0;
      bi    = 1'b0;
      for (int i = 0; i < DIGIT; i++) begin
         ai    = (msb_swap && (i == DIGIT - 1)) ? b_d[i] : a_d[i];
         bi    = (msb_swap && (i == DIGIT - 1)) ? a_d[i] : b_d[i];
         n_out = (n_out & (~ai | bi)) | (~ai & bi);
         e_out = e_out & (ai == bi);
      end
   end
endmodule

// File: rtl/serial_comparator_di.sv
// rtl/serial_comparator_di.sv - LSB-first serial magnitude comparator, DIGIT bits per clock
module serial_comparator_di
   import serial_cmp_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter int DIGIT     = 1,
   parameter int SIGNED_EN = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   serial_comparator_di_if.slave bus
);
   localparam int N     = WIDTH / DIGIT;
   localparam int CNT_W = (clog2(N) < 1) ? 1 : clog2(N);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N - 1);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             mode_q, mode_d;
   logic             n_q, n_d;
   logic             e_q, e_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             lt_q, lt_d;
   logic             eq_q, eq_d;
   logic             gt_q, gt_d;

   logic             last_digit;
   logic             n_dig;
   logic             e_dig;

   assign last_digit = (state_q == RUN) && (cnt_q == LAST_CNT);

   lt_digit_di #(.DIGIT(DIGIT)) u_digit (
      .a_d      (a_q[DIGIT-1:0]),
      .b_d      (b_q[DIGIT-1:0]),
      .n_in     (n_q),
      .e_in     (e_q),
      .msb_swap (last_digit && (mode_q == CMP_SIGNED)),
      .n_out    (n_dig),
      .e_out    (e_dig)
   );

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      cnt_d   = cnt_q;
      mode_d  = mode_q;
      n_d     = n_q;
      e_d     = e_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      lt_d    = lt_q;
      eq_d    = eq_q;
      gt_d    = gt_q;
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               a_d     = bus.a;
               b_d     = bus.b;
               mode_d  = (SIGNED_EN != 0) ? bus.signed_mode : CMP_UNSIGNED;
               n_d     = 1'b0;
               e_d     = 1'b1;
               cnt_d   = '0;
               busy_d  = 1'b1;
               lt_d    = 1'b0;
               eq_d    = 1'b0;
               gt_d    = 1'b0;
               state_d = RUN;
            end
         end
         RUN: begin
            a_d   = a_q >> DIGIT;
            b_d   = b_q >> DIGIT;
            n_d   = n_dig;
            e_d   = e_dig;
            cnt_d = cnt_q + CNT_W'(1);
            if (last_digit) begin
               lt_d    = n_dig;
               eq_d    = e_dig;
               gt_d    = ~n_dig & ~e_dig;
               done_d  = 1'b1;
               busy_d  = 1'b0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         cnt_q   <= '0;
         mode_q  <= CMP_UNSIGNED;
         n_q     <= 1'b0;
         e_q     <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         lt_q    <= 1'b0;
         eq_q    <= 1'b0;
         gt_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         cnt_q   <= cnt_d;
         mode_q  <= mode_d;
         n_q     <= n_d;
         e_q     <= e_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         lt_q    <= lt_d;
         eq_q    <= eq_d;
         gt_q    <= gt_d;
      end
   end

   assign bus.busy = busy_q;
   assign bus.done = done_q;
   assign bus.lt   = lt_q;
   assign bus.eq   = eq_q;
   assign bus.gt   = gt_q;
endmodule

// File: tb/tb_serial_comparator_di.sv
// tb/tb_serial_comparator_di.sv - randomized and directed bench for the serial comparator
module tb_serial_comparator_di;
   logic clk = 1'b0;
   logic rst_n;
   int   checks   = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   serial_comparator_di_if #(.WIDTH(8)) if1 ();
   serial_comparator_di_if #(.WIDTH(8)) if2 ();

   serial_comparator_di #(.WIDTH(8), .DIGIT(1), .SIGNED_EN(1)) dut1 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (if1.slave)
   );

   serial_comparator_di #(.WIDTH(8), .DIGIT(2), .SIGNED_EN(1)) dut2 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (if2.slave)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic drive(input int sel, input logic st, input logic [7:0] a, input logic [7:0] b,
                        input logic sm);
      if (sel == 0) begin
         if1.start = st; if1.a = a; if1.b = b; if1.signed_mode = sm;
      end else begin
         if2.start = st; if2.a = a; if2.b = b; if2.signed_mode = sm;
      end
   endtask

   // {busy, done, lt, eq, gt}
   function automatic logic [4:0] outs(input int sel);
      if (sel == 0) return {if1.busy, if1.done, if1.lt, if1.eq, if1.gt};
      return {if2.busy, if2.done, if2.lt, if2.eq, if2.gt};
   endfunction

   // {lt, eq, gt} from plain integer ordering
   function automatic logic [2:0] model(input logic [7:0] a, input logic [7:0] b, input logic sm);
      int av;
      int bv;
      av = sm ? int'($signed(a)) : int'(a);
      bv = sm ? int'($signed(b)) : int'(b);
      return {av < bv, av == bv, av > bv};
   endfunction

   task automatic wait_done(input int sel, output int lat, output int busy_cnt);
      logic [4:0] o;
      lat = 0;
      busy_cnt = 1;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         o = outs(sel);
         if (o[3]) begin
            lat = k;
            break;
         end
         if (o[4]) busy_cnt++;
      end
   endtask

   task automatic cmp(input int sel, input logic [7:0] a, input logic [7:0] b, input logic sm,
                      input string tag);
      int         n;
      int         lat;
      int         busy_cnt;
      logic [2:0] exp;
      logic [4:0] o;
      n   = (sel == 0) ? 8 : 4;
      exp = model(a, b, sm);
      @(negedge clk);
      drive(sel, 1'b1, a, b, sm);
      @(negedge clk);
      drive(sel, 1'b0, 8'($urandom), 8'($urandom), 1'($urandom));
      o = outs(sel);
      chk({tag, "_accept"}, {27'd0, o}, {27'd0, 5'b10000});
      wait_done(sel, lat, busy_cnt);
      o = outs(sel);
      chk({tag, "_lat"}, lat, n);
      chk({tag, "_busy"}, busy_cnt, n);
      chk({tag, "_res"}, {29'd0, o[2:0]}, {29'd0, exp});
      @(negedge clk);
      o = outs(sel);
      chk({tag, "_hold"}, {27'd0, o}, {27'd0, 2'b00, exp});
   endtask

   initial begin
      logic [4:0] o;
      int         lat;
      int         busy_cnt;
      int         dones;

      rst_n = 1'b0;
      drive(0, 1'b0, 8'h00, 8'h00, 1'b0);
      drive(1, 1'b0, 8'h00, 8'h00, 1'b0);
      repeat (2) @(negedge clk);
      chk("reset1", {27'd0, outs(0)}, 32'd0);
      chk("reset2", {27'd0, outs(1)}, 32'd0);
      rst_n = 1'b1;

      cmp(0, 8'h03, 8'h05, 1'b0, "u_3_5");
      cmp(0, 8'h80, 8'h01, 1'b0, "u_80_01");
      cmp(0, 8'h80, 8'h01, 1'b1, "s_80_01");
      cmp(0, 8'hFF, 8'hFE, 1'b1, "s_ff_fe");
      cmp(0, 8'hA5, 8'hA5, 1'b0, "u_a5_a5");
      cmp(0, 8'h00, 8'h00, 1'b1, "s_00_00");
      cmp(0, 8'h7F, 8'h80, 1'b1, "s_7f_80");
      cmp(1, 8'h10, 8'h0F, 1'b0, "d2_10_0f");
      cmp(1, 8'h80, 8'h7F, 1'b1, "d2_s_80_7f");
      cmp(1, 8'h5A, 8'h5A, 1'b1, "d2_eq");

      // start held through the compare, then coincident with done
      @(negedge clk);
      drive(0, 1'b1, 8'h09, 8'h02, 1'b0);
      @(negedge clk);
      drive(0, 1'b1, 8'h01, 8'h02, 1'b0);
      wait_done(0, lat, busy_cnt);
      o = outs(0);
      chk("b2b_lat1", lat, 8);
      chk("b2b_res1", {29'd0, o[2:0]}, {29'd0, 3'b001});
      @(negedge clk);
      drive(0, 1'b0, 8'h00, 8'h00, 1'b0);
      o = outs(0);
      chk("b2b_accept2", {27'd0, o}, {27'd0, 5'b10000});
      wait_done(0, lat, busy_cnt);
      o = outs(0);
      chk("b2b_lat2", lat, 8);
      chk("b2b_res2", {29'd0, o[2:0]}, {29'd0, 3'b100});

      // abort mid-compare
      @(negedge clk);
      drive(0, 1'b1, 8'h33, 8'h44, 1'b0);
      @(negedge clk);
      drive(0, 1'b0, 8'h00, 8'h00, 1'b0);
      repeat (2) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("abort_outs", {27'd0, outs(0)}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      dones = 0;
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         o = outs(0);
         if (o[3]) dones++;
      end
      chk("abort_nodone", dones, 0);
      cmp(0, 8'h05, 8'h05, 1'b0, "post_abort");

      for (int i = 0; i < 30; i++)
         cmp(0, 8'($urandom), 8'($urandom), 1'($urandom), "rnd1");
      for (int i = 0; i < 20; i++)
         cmp(1, 8'($urandom), 8'($urandom), 1'($urandom), "rnd2");
      for (int i = 0; i < 5; i++) begin
         logic [7:0] v;
         v = 8'($urandom);
         cmp(1, v, v, 1'($urandom), "rnd2_eq");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
